// File: rtl/unidade_busca.sv
// Fetch stage: owns the PC, captures instructions into the IR and hands them to decode over valid/ready.
// Optional PC overflow trap enabled by defining FETCH_WRAP_TRAP_EN.
module unidade_busca #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [DATA_W-1:0] instr_in,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              dec_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic              halted,
    output logic              wrap_err
);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_HALT
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc_nx;
    logic [DATA_W-1:0]   ir_nx;
    logic [ADDR_W-1:0]   ir_pc_nx;
    logic                valid_nx;
    logic                stall;
    logic                wrap_set;

    assign stall  = ir_valid && !dec_ready;
    assign halted = (state == S_HALT);

    // Priority in S_RUN: halt, then branch (overrides stall), then stall, then advance.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_out;
        ir_nx    = ir_out;
        ir_pc_nx = ir_pc;
        valid_nx = ir_valid;
        wrap_set = 1'b0;
        case (state)
            S_INIT: begin
                if (halt_req) begin
                    state_nx = S_HALT;
                end else if (branch_valid) begin
                    pc_nx = branch_target;
                end else begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_nx = S_HALT;
                    valid_nx = 1'b0;
                end else if (branch_valid) begin
                    pc_nx    = branch_target;
                    valid_nx = 1'b0;
                end else if (!stall) begin
                    ir_nx    = instr_in;
                    ir_pc_nx = pc_out;
                    valid_nx = 1'b1;
`ifdef FETCH_WRAP_TRAP_EN
                    // The last address is still captured, but fetching stops there.
                    if (pc_out == {ADDR_W{1'b1}}) begin
                        state_nx = S_HALT;
                        valid_nx = 1'b0;
                        wrap_set = 1'b1;
                    end else begin
                        pc_nx = pc_out + ADDR_W'(1);
                    end
`else
                    pc_nx = pc_out + ADDR_W'(1);
`endif
                end
            end
            S_HALT: begin
                valid_nx = 1'b0;
            end
            default: begin
                state_nx = S_INIT;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            pc_out   <= RESET_PC;
            ir_out   <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_out   <= pc_nx;
            ir_out   <= ir_nx;
            ir_pc    <= ir_pc_nx;
            ir_valid <= valid_nx;
        end
    end

`ifdef FETCH_WRAP_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_err <= 1'b0;
        end else if (wrap_set) begin
            wrap_err <= 1'b1;
        end
    end
`else
    assign wrap_err = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Directed self-checking bench for unidade_busca with a negedge-read instruction memory model.
// Covers the FETCH_WRAP_TRAP_EN variant when that macro is defined for the build.
module tb_unidade_busca;

    logic       clk;
    logic       rst_n;
    logic [7:0] pc_out;
    logic [7:0] instr_in;
    logic [7:0] ir_out;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       dec_ready;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       halt_req;
    logic       halted;
    logic       wrap_err;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] mem [256];

    unidade_busca dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_out       (pc_out),
        .instr_in     (instr_in),
        .ir_out       (ir_out),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .dec_ready    (dec_ready),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .halted       (halted),
        .wrap_err     (wrap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns mem[pc_out] sampled at the falling edge; contents are addr + 8'hA0.
    always @(negedge clk) instr_in = mem[pc_out];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic br, input logic [7:0] tgt, input logic hlt);
        dec_ready     = rdy;
        branch_valid  = br;
        branch_target = tgt;
        halt_req      = hlt;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFetch(input string tag, input logic [7:0] expIr, input logic [7:0] expIrPc,
                              input logic expValid, input logic [7:0] expPc);
        checkOutput({tag, ".ir_out"},   ir_out,   expIr);
        checkOutput({tag, ".ir_pc"},    ir_pc,    expIrPc);
        checkOutput({tag, ".ir_valid"}, ir_valid, expValid);
        checkOutput({tag, ".pc_out"},   pc_out,   expPc);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'hA0);
        instr_in = 8'h00;
        rst_n    = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

        // Reset values
        #2;
        checkFetch("reset", 8'h00, 8'h00, 1'b0, 8'h00);
        checkOutput("reset.halted",   halted,   1'b0);
        checkOutput("reset.wrap_err", wrap_err, 1'b0);
        #4 rst_n = 1'b1;

        // Test 1: init bubble, then A0..A3 back to back
        stepCycle(); checkFetch("t1.init", 8'h00, 8'h00, 1'b0, 8'h00);
        stepCycle(); checkFetch("t1.a0",   8'hA0, 8'h00, 1'b1, 8'h01);
        stepCycle(); checkFetch("t1.a1",   8'hA1, 8'h01, 1'b1, 8'h02);

        // Test 2: stall three cycles on A1, then A2 with no skip/duplicate
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle(); checkFetch("t2.stall", 8'hA1, 8'h01, 1'b1, 8'h02);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle(); checkFetch("t2.a2", 8'hA2, 8'h02, 1'b1, 8'h03);

        // Test 3: stall on A2, branch to 40 overrides the stall
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        stepCycle(); checkFetch("t3.stall", 8'hA2, 8'h02, 1'b1, 8'h03);
        applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
        stepCycle(); checkFetch("t3.bubble", 8'hA2, 8'h02, 1'b0, 8'h40);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle(); checkFetch("t3.target", 8'hE0, 8'h40, 1'b1, 8'h41);

        // Test 4: move pc to 5, then halt together with a branch
        applyStimulus(1'b1, 1'b1, 8'h05, 1'b0);
        stepCycle(); checkFetch("t4.br5", 8'hE0, 8'h40, 1'b0, 8'h05);
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b1);
        stepCycle();
        checkFetch("t4.halt", 8'hE0, 8'h40, 1'b0, 8'h05);
        checkOutput("t4.halted", halted, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle(); checkFetch("t4.frozen", 8'hE0, 8'h40, 1'b0, 8'h05);
            checkOutput("t4.halted_hold", halted, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4.rst_pc",     pc_out, 8'h00);
        checkOutput("t4.rst_halted", halted, 1'b0);
        #1 rst_n = 1'b1;

        // Test 5: restart, branch to FE and run across the top of the address space
        stepCycle(); checkFetch("t5.init", 8'h00, 8'h00, 1'b0, 8'h00);
        stepCycle(); checkFetch("t5.a0",   8'hA0, 8'h00, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'hFE, 1'b0);
        stepCycle(); checkFetch("t5.bubble", 8'hA0, 8'h00, 1'b0, 8'hFE);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        stepCycle(); checkFetch("t5.fe", 8'h9E, 8'hFE, 1'b1, 8'hFF);
`ifdef FETCH_WRAP_TRAP_EN
        stepCycle(); checkFetch("t5.ff_trap", 8'h9F, 8'hFF, 1'b0, 8'hFF);
        checkOutput("t5.halted",   halted,   1'b1);
        checkOutput("t5.wrap_err", wrap_err, 1'b1);
        stepCycle(); checkFetch("t5.trap_hold", 8'h9F, 8'hFF, 1'b0, 8'hFF);
        checkOutput("t5.wrap_sticky", wrap_err, 1'b1);
`else
        stepCycle(); checkFetch("t5.ff", 8'h9F, 8'hFF, 1'b1, 8'h00);
        stepCycle(); checkFetch("t5.00", 8'hA0, 8'h00, 1'b1, 8'h01);
        stepCycle(); checkFetch("t5.01", 8'hA1, 8'h01, 1'b1, 8'h02);
        checkOutput("t5.wrap_err", wrap_err, 1'b0);
        checkOutput("t5.halted",   halted,   1'b0);
`endif

        // Test 6: asynchronous reset between clock edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkFetch("t6.async", 8'h00, 8'h00, 1'b0, 8'h00);
        checkOutput("t6.halted",   halted,   1'b0);
        checkOutput("t6.wrap_err", wrap_err, 1'b0);
        #2 rst_n = 1'b1;
        stepCycle(); checkFetch("t6.init", 8'h00, 8'h00, 1'b0, 8'h00);
        stepCycle(); checkFetch("t6.a0",   8'hA0, 8'h00, 1'b1, 8'h01);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
